// File: rtl/ring_pkg.sv
// Shared types and constants for the ring grant controller.
// Station bit order follows the ring: bit 0 is station A, bit 7 is station H.
package ring_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PERMIT = 3'd1,
    SETTLE      = 3'd2,
    ACTIVE      = 3'd3,
    FAULT       = 3'd4
  } station_state_t;

  localparam int NUM_STATIONS_DEF = 8;

  localparam int ST_A = 0;
  localparam int ST_B = 1;
  localparam int ST_C = 2;
  localparam int ST_D = 3;
  localparam int ST_E = 4;
  localparam int ST_F = 5;
  localparam int ST_G = 6;
  localparam int ST_H = 7;

endpackage

// File: rtl/ring_station_ch.sv
// One ring station: request sync/debounce plus grant FSM.
// state | meaning: IDLE no request | WAIT_PERMIT req latched, waiting | SETTLE permit qualifying | ACTIVE granted | FAULT permit lost while granted
module ring_station_ch
  import ring_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 3,
  parameter int MIN_ON_CYCLES   = 5
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic req,
  input  logic permit,
  input  logic done,
  input  logic fault_clr,
  output logic req_latched,
  output logic grant,
  output logic fault,
  output logic active
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_ON_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [SET_W-1:0]  SET_MAX  = SET_W'(SETTLE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_ON_CYCLES);

  logic [1:0]        sync_q;
  logic              req_db;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_inc;

  station_state_t    state, state_nxt;
  logic [SET_W-1:0]  set_cnt, set_nxt, set_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              rel_pend, rel_nxt;
  logic              release_req;

  assign db_inc = db_cnt + 1'b1;

  // Counter only ever climbs to DEBOUNCE_CYCLES, where it toggles and clears.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= 2'b00;
      req_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], req};
      if (sync_q[1] == req_db) begin
        db_cnt <= '0;
      end else if (db_inc == DB_MAX) begin
        req_db <= ~req_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_inc;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      set_cnt  <= '0;
      hold_cnt <= '0;
      rel_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      set_cnt  <= set_nxt;
      hold_cnt <= hold_nxt;
      rel_pend <= rel_nxt;
    end
  end

  assign set_inc     = set_cnt + 1'b1;
  assign release_req = rel_pend | done | ~req_db;

  always_comb begin
    state_nxt = state;
    set_nxt   = set_cnt;
    hold_nxt  = hold_cnt;
    rel_nxt   = rel_pend;
    unique case (state)
      IDLE: begin
        if (req_db) state_nxt = WAIT_PERMIT;
      end
      WAIT_PERMIT: begin
        if (!req_db) begin
          state_nxt = IDLE;
        end else if (permit) begin
          if (SETTLE_CYCLES == 1) begin
            state_nxt = ACTIVE;
            hold_nxt  = HOLD_W'(1);
            rel_nxt   = 1'b0;
          end else begin
            state_nxt = SETTLE;
            set_nxt   = SET_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!permit) begin
          state_nxt = WAIT_PERMIT;
          set_nxt   = '0;
        end else if (!req_db) begin
          state_nxt = IDLE;
          set_nxt   = '0;
        end else if (set_inc == SET_MAX) begin
          state_nxt = ACTIVE;
          set_nxt   = '0;
          hold_nxt  = HOLD_W'(1);
          rel_nxt   = 1'b0;
        end else begin
          set_nxt = set_inc;
        end
      end
      ACTIVE: begin
        // Permit loss wins over any release, whatever the hold count.
        if (!permit) begin
          state_nxt = FAULT;
          hold_nxt  = '0;
          rel_nxt   = 1'b0;
        end else if (release_req && (hold_cnt == HOLD_MAX)) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
          rel_nxt   = 1'b0;
        end else begin
          rel_nxt = release_req;
          if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr && !req_db) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req_latched = req_db;
  assign active      = (state == ACTIVE);
  assign grant       = active & permit;
  assign fault       = (state == FAULT);

endmodule

// File: rtl/ring_grant_ctrl.sv
// Sequential front/back stage around the ring interlock: one channel per
// station plus a registered count of stations currently in ACTIVE.
module ring_grant_ctrl
  import ring_pkg::*;
#(
  parameter int NUM_STATIONS    = NUM_STATIONS_DEF,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 3,
  parameter int MIN_ON_CYCLES   = 5
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_STATIONS-1:0]             i_req,
  input  logic [NUM_STATIONS-1:0]             i_permit,
  input  logic [NUM_STATIONS-1:0]             i_done,
  input  logic                                i_fault_clr,
  output logic [NUM_STATIONS-1:0]             o_req_latched,
  output logic [NUM_STATIONS-1:0]             o_grant,
  output logic [NUM_STATIONS-1:0]             o_fault,
  output logic [$clog2(NUM_STATIONS+1)-1:0]   o_active_cnt
);

  localparam int CNT_W = $clog2(NUM_STATIONS + 1);

  logic [NUM_STATIONS-1:0] active;
  logic [CNT_W-1:0]        active_sum;

  for (genvar n = 0; n < NUM_STATIONS; n++) begin : g_station
    ring_station_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SETTLE_CYCLES   (SETTLE_CYCLES),
      .MIN_ON_CYCLES   (MIN_ON_CYCLES)
    ) u_ch (
      .clk_sys     (i_clk),
      .rst_b       (i_rst_n),
      .req         (i_req[n]),
      .permit      (i_permit[n]),
      .done        (i_done[n]),
      .fault_clr   (i_fault_clr),
      .req_latched (o_req_latched[n]),
      .grant       (o_grant[n]),
      .fault       (o_fault[n]),
      .active      (active[n])
    );
  end

  // Counts FSM ACTIVE state, not the permit-gated grant.
  always_comb begin
    active_sum = '0;
    for (int n = 0; n < NUM_STATIONS; n++) begin
      active_sum = active_sum + CNT_W'(active[n]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_active_cnt <= '0;
    else          o_active_cnt <= active_sum;
  end

endmodule
